// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared widths, defaults and clear-state encoding for fb_arbiter
package fb_pkg;
  localparam int ADDR_W        = 19;
  localparam int COLOR_W       = 9;
  localparam int FB_PIXELS_DEF = 307200;
  localparam int ENTRY_W       = ADDR_W + COLOR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } drw_entry_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - draw-write FIFO with full/empty flags and async active-low reset
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[PTR_W-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - frame-buffer port arbiter: video read > clear write > draw FIFO write
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int FB_PIXELS  = FB_PIXELS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vid_req,
  input  logic [ADDR_W-1:0]  vid_addr,
  output logic               vid_valid,
  output logic [COLOR_W-1:0] vid_data,
  input  logic               drw_valid,
  output logic               drw_ready,
  input  logic [ADDR_W-1:0]  drw_addr,
  input  logic [COLOR_W-1:0] drw_color,
  input  logic               clr_start,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_busy,
  output logic               clr_done,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  output logic               fb_we,
  output logic               fb_re,
  input  logic [COLOR_W-1:0] fb_rdata
);
  localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W+1)'(FB_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  clr_state_e         r_state;
  clr_state_e         w_state_nxt;
  logic [ADDR_W-1:0]  r_clr_cnt;
  logic [COLOR_W-1:0] r_clr_color;
  logic               r_ready_en;
  logic               r_vid_valid;
  logic               r_vid_oor;
  drw_entry_t         w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_ready;
  logic               w_vid_in;
  logic               w_head_in;
  logic               w_clr_gnt;
  logic               w_drw_gnt;

  assign w_vid_in  = ({1'b0, vid_addr} < PIX_LIMIT);
  assign w_head_in = ({1'b0, w_head.addr} < PIX_LIMIT);
  assign w_clr_gnt = !vid_req && (r_state == CLEAR);
  // The FIFO is frozen while a clear is running so the clear owns the write port.
  assign w_drw_gnt = !vid_req && (r_state != CLEAR) && !w_empty;
  assign w_ready   = r_ready_en && !w_full;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (drw_valid && w_ready),
    .i_wdata ({drw_addr, drw_color}),
    .i_pop   (w_drw_gnt),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clr_start) w_state_nxt = CLEAR;
      CLEAR:   if (w_clr_gnt && (r_clr_cnt == LAST_ADDR)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
    end else if ((r_state == IDLE) && clr_start) begin
      r_clr_cnt   <= '0;
      r_clr_color <= clr_color;
    end else if (w_clr_gnt) begin
      r_clr_cnt <= (r_clr_cnt == LAST_ADDR) ? '0 : r_clr_cnt + ADDR_W'(1);
    end
  end

  // r_ready_en keeps drw_ready low for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en  <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_oor   <= 1'b0;
    end else begin
      r_ready_en  <= 1'b1;
      r_vid_valid <= vid_req;
      r_vid_oor   <= !w_vid_in;
    end
  end

  always_comb begin
    fb_we    = 1'b0;
    fb_re    = 1'b0;
    fb_addr  = '0;
    fb_wdata = '0;
    if (vid_req) begin
      if (w_vid_in) begin
        fb_re   = 1'b1;
        fb_addr = vid_addr;
      end
    end else if (w_clr_gnt) begin
      fb_we    = 1'b1;
      fb_addr  = r_clr_cnt;
      fb_wdata = r_clr_color;
    end else if (w_drw_gnt && w_head_in) begin
      fb_we    = 1'b1;
      fb_addr  = w_head.addr;
      fb_wdata = w_head.color;
    end
  end

  assign vid_valid = r_vid_valid;
  assign vid_data  = (r_vid_valid && !r_vid_oor) ? fb_rdata : '0;
  assign drw_ready = w_ready;
  assign clr_busy  = (r_state != IDLE);
  assign clr_done  = (r_state == DONE);
endmodule
